// File: rtl/fht_seq_pkg.sv
// Shared types for the FHT host-side sequencer: state encoding and bank-select decode.
// Purely declarative; no logic lives here.
package fht_seq_pkg;

    localparam int N_BANK = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        UNLOAD
    } seq_state_t;

    function automatic logic [N_BANK-1:0] bank_onehot(input logic [1:0] sel);
        return N_BANK'(1) << sel;
    endfunction

endpackage

// File: rtl/fht_skid_buf2.sv
// Two-entry valid/ready buffer with occupancy count; a pushed word is visible the next cycle.
// Backpressure: o_in_rdy drops only when full and not popping; o_out_dat holds while stalled.
module fht_skid_buf2 #(
    parameter int D_BIT = 16
) (
    input  logic             i_core_clk,
    input  logic             i_arst_n,
    input  logic [D_BIT-1:0] i_in_dat,
    input  logic             i_in_vld,
    output logic             o_in_rdy,
    output logic [D_BIT-1:0] o_out_dat,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic [1:0]       o_cnt
);

    logic [D_BIT-1:0] r_head;
    logic [D_BIT-1:0] r_tail;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_out_vld = (r_cnt != 2'd0);
    assign o_in_rdy  = (r_cnt != 2'd2) || i_out_rdy;
    assign o_out_dat = r_head;
    assign o_cnt     = r_cnt;
    assign w_push    = i_in_vld && o_in_rdy;
    assign w_pop     = o_out_vld && i_out_rdy;

    // r_head is always the oldest entry, so the output never needs a read mux.
    always_ff @(posedge i_core_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_in_dat;
                    else               r_tail <= i_in_dat;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= i_in_dat;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_in_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fht_io_sequencer.sv
// Loads a frame of N samples into fht_top's four banks, starts the transform, then streams results out.
// Writes land 1 cycle after each input handshake; results flow through a 2-entry skid buffer under iM_READY.
module fht_io_sequencer
    import fht_seq_pkg::*;
#(
    parameter int D_BIT  = 16,
    parameter int A_BIT  = 8,
    parameter int RD_LAT = 1
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [D_BIT-1:0]  iS_DATA,
    input  logic              iS_VALID,
    output logic              oS_READY,
    output logic [D_BIT-1:0]  oM_DATA,
    output logic              oM_VALID,
    input  logic              iM_READY,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [N_BANK-1:0] oFHT_WE,
    output logic [D_BIT-1:0]  oFHT_DATA,
    output logic [A_BIT-1:0]  oFHT_ADDR_WR,
    output logic [A_BIT-1:0]  oFHT_ADDR_RD,
    output logic              oFHT_START,
    input  logic [D_BIT-1:0]  iFHT_DATA_0,
    input  logic [D_BIT-1:0]  iFHT_DATA_1,
    input  logic [D_BIT-1:0]  iFHT_DATA_2,
    input  logic [D_BIT-1:0]  iFHT_DATA_3,
    input  logic              iFHT_RDY
);

    localparam int             CW       = A_BIT + 2;
    localparam logic [CW-1:0]  LAST_IDX = {CW{1'b1}};

    if (RD_LAT != 1) begin : g_rd_lat_unsupported
        $error("fht_io_sequencer supports RD_LAT = 1 only");
    end

    seq_state_t        r_state;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_cnt;
    logic [CW-1:0]     r_out_cnt;
    logic              r_rd_all;
    logic              r_inflight;
    logic [1:0]        r_bank_d;
    logic              r_s_ready;
    logic [N_BANK-1:0] r_we;
    logic [A_BIT-1:0]  r_addr_wr;
    logic [D_BIT-1:0]  r_wdata;
    logic              r_start;
    logic              r_done;

    logic              w_s_hs;
    logic              w_m_hs;
    logic              w_issue;
    logic [2:0]        w_credit;
    logic [D_BIT-1:0]  w_rd_data;
    logic              w_sb_in_rdy;
    logic              w_sb_out_vld;
    logic [D_BIT-1:0]  w_sb_out_dat;
    logic [1:0]        w_sb_cnt;

    // In IDLE the first sample waits for fht_top to be idle; once loading, RDY is ignored.
    assign oS_READY = r_s_ready && ((r_state == LOAD) || iFHT_RDY);
    assign w_s_hs   = iS_VALID && oS_READY;
    assign w_m_hs   = w_sb_out_vld && iM_READY;

    // Occupancy left after this cycle's pop plus reads still in flight; keeps the buffer from overflowing.
    assign w_credit = {1'b0, w_sb_cnt} + {2'b0, r_inflight} - {2'b0, w_m_hs};
    assign w_issue  = (r_state == UNLOAD) && !r_rd_all && (w_credit < 3'd2) && w_sb_in_rdy;

    always_comb begin
        w_rd_data = iFHT_DATA_0;
        case (r_bank_d)
            2'd1:    w_rd_data = iFHT_DATA_1;
            2'd2:    w_rd_data = iFHT_DATA_2;
            2'd3:    w_rd_data = iFHT_DATA_3;
            default: w_rd_data = iFHT_DATA_0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_rd_all   <= 1'b0;
            r_inflight <= 1'b0;
            r_bank_d   <= 2'd0;
            r_s_ready  <= 1'b0;
            r_we       <= '0;
            r_addr_wr  <= '0;
            r_wdata    <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we       <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            if (w_s_hs) begin
                r_we      <= bank_onehot(r_wr_cnt[1:0]);
                r_addr_wr <= r_wr_cnt[CW-1:2];
                r_wdata   <= iS_DATA;
                r_wr_cnt  <= r_wr_cnt + 1'b1;
            end

            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                r_bank_d <= r_rd_cnt[1:0];
                if (r_rd_cnt == LAST_IDX) r_rd_all <= 1'b1;
            end

            if (w_m_hs) r_out_cnt <= r_out_cnt + 1'b1;

            case (r_state)
                IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_s_hs) r_state <= LOAD;
                end
                LOAD: begin
                    if (w_s_hs && (r_wr_cnt == LAST_IDX)) begin
                        r_s_ready <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    r_s_ready <= 1'b0;
                    r_start   <= 1'b1;
                    r_state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    r_s_ready <= 1'b0;
                    if (!iFHT_RDY) r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    r_s_ready <= 1'b0;
                    if (iFHT_RDY) r_state <= UNLOAD;
                end
                UNLOAD: begin
                    r_s_ready <= 1'b0;
                    if (w_m_hs && (r_out_cnt == LAST_IDX)) begin
                        r_done   <= 1'b1;
                        r_rd_all <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    fht_skid_buf2 #(
        .D_BIT (D_BIT)
    ) u_res_buf (
        .i_core_clk (iCLK),
        .i_arst_n   (iRESET),
        .i_in_dat   (w_rd_data),
        .i_in_vld   (r_inflight),
        .o_in_rdy   (w_sb_in_rdy),
        .o_out_dat  (w_sb_out_dat),
        .o_out_vld  (w_sb_out_vld),
        .i_out_rdy  (iM_READY),
        .o_cnt      (w_sb_cnt)
    );

    assign oM_DATA      = w_sb_out_dat;
    assign oM_VALID     = w_sb_out_vld;
    assign oBUSY        = (r_state != IDLE);
    assign oDONE        = r_done;
    assign oFHT_WE      = r_we;
    assign oFHT_DATA    = r_wdata;
    assign oFHT_ADDR_WR = r_addr_wr;
    assign oFHT_ADDR_RD = r_rd_cnt[CW-1:2];
    assign oFHT_START   = r_start;

endmodule

// File: tb/tb_fht_io_sequencer.sv
// Bench for fht_io_sequencer with a behavioural fht_top (4 banks, 1-cycle read, RDY busy window).
// Frames are checked against the RAM-order rule k -> bank k%4, addr k/4.
module tb_fht_io_sequencer;

    localparam int D_BIT = 16;
    localparam int A_BIT = 2;
    localparam int N     = 16;

    logic              iCLK = 1'b0;
    logic              iRESET;
    logic [D_BIT-1:0]  iS_DATA;
    logic              iS_VALID;
    logic              oS_READY;
    logic [D_BIT-1:0]  oM_DATA;
    logic              oM_VALID;
    logic              iM_READY;
    logic              oBUSY;
    logic              oDONE;
    logic [3:0]        oFHT_WE;
    logic [D_BIT-1:0]  oFHT_DATA;
    logic [A_BIT-1:0]  oFHT_ADDR_WR;
    logic [A_BIT-1:0]  oFHT_ADDR_RD;
    logic              oFHT_START;
    logic [D_BIT-1:0]  iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3;
    logic              iFHT_RDY;

    always #5 iCLK = ~iCLK;

    fht_io_sequencer #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(1)) dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
        .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY),
        .oBUSY(oBUSY), .oDONE(oDONE),
        .oFHT_WE(oFHT_WE), .oFHT_DATA(oFHT_DATA),
        .oFHT_ADDR_WR(oFHT_ADDR_WR), .oFHT_ADDR_RD(oFHT_ADDR_RD),
        .oFHT_START(oFHT_START),
        .iFHT_DATA_0(iFHT_DATA_0), .iFHT_DATA_1(iFHT_DATA_1),
        .iFHT_DATA_2(iFHT_DATA_2), .iFHT_DATA_3(iFHT_DATA_3),
        .iFHT_RDY(iFHT_RDY)
    );

    // ---------------- fht_top model ----------------
    logic [D_BIT-1:0] ram [4][4];
    logic [D_BIT-1:0] rd_q [4];
    logic m_rdy = 1'b1;
    logic rdy_glitch = 1'b0;
    int   m_hold = 0, m_low = 0;
    bit   m_act = 1'b0;
    int   cfg_hold = 3, cfg_low = 20, cfg_tf = 0;

    assign iFHT_DATA_0 = rd_q[0];
    assign iFHT_DATA_1 = rd_q[1];
    assign iFHT_DATA_2 = rd_q[2];
    assign iFHT_DATA_3 = rd_q[3];
    assign iFHT_RDY    = m_rdy & ~rdy_glitch;

    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (oFHT_WE[b]) ram[b][oFHT_ADDR_WR] <= oFHT_DATA;
            rd_q[b] <= ram[b][oFHT_ADDR_RD];
        end
        if (oFHT_START) begin
            m_hold <= cfg_hold;
            m_low  <= cfg_low;
            m_act  <= 1'b1;
        end else if (m_act) begin
            if (m_hold > 0) m_hold <= m_hold - 1;
            else if (m_low > 0) begin
                m_rdy <= 1'b0;
                m_low <= m_low - 1;
            end else begin
                m_rdy <= 1'b1;
                m_act <= 1'b0;
                for (int b = 0; b < 4; b++)
                    for (int a = 0; a < 4; a++)
                        ram[b][a] <= (cfg_tf == 0) ? 16'(b * 100 + a) : (ram[b][a] ^ 16'hA5C3);
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    logic [21:0]      wr_q[$];
    logic [D_BIT-1:0] got_q[$];
    int  start_cnt = 0, done_cnt = 0, start_cyc = -1, done_cyc = -1;
    int  last_we_cyc = -1, last_hs_cyc = -1, first_vld_cyc = -1, rise_cyc = -1;
    int  stab_viol = 0, sready_viol = 0;
    bit  prev_stall = 1'b0, prev_rdy = 1'b1;
    logic [D_BIT-1:0] prev_dat = '0;
    bit  mon_clr = 1'b0, loaded_flag = 1'b0;

    always @(negedge iCLK) begin
        if (mon_clr) begin
            wr_q.delete();
            got_q.delete();
            start_cnt = 0; done_cnt = 0; start_cyc = -1; done_cyc = -1;
            last_we_cyc = -1; last_hs_cyc = -1; first_vld_cyc = -1; rise_cyc = -1;
            stab_viol = 0; sready_viol = 0; prev_stall = 1'b0; prev_rdy = iFHT_RDY;
        end else if (iRESET) begin
            if (|oFHT_WE) begin
                wr_q.push_back({oFHT_WE, oFHT_ADDR_WR, oFHT_DATA});
                last_we_cyc = cyc;
            end
            if (oFHT_START) begin start_cnt++; start_cyc = cyc; end
            if (iFHT_RDY && !prev_rdy) rise_cyc = cyc;
            prev_rdy = iFHT_RDY;
            if (oM_VALID && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (oM_VALID && iM_READY) begin got_q.push_back(oM_DATA); last_hs_cyc = cyc; end
            if (prev_stall && (!oM_VALID || oM_DATA != prev_dat)) stab_viol++;
            prev_stall = oM_VALID && !iM_READY;
            prev_dat   = oM_DATA;
            if (oDONE) begin done_cnt++; done_cyc = cyc; end
            if (loaded_flag && oBUSY && oS_READY) sready_viol++;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [D_BIT-1:0] samples [N];
    logic [D_BIT-1:0] exp_res [N];

    task automatic clear_logs();
        mon_clr = 1'b1;
        @(negedge iCLK);
        @(posedge iCLK); #1;
        mon_clr = 1'b0;
    endtask

    task automatic gen_samples(input int dmode);
        for (int k = 0; k < N; k++) samples[k] = (dmode == 0) ? 16'(k) : 16'($urandom);
    endtask

    task automatic load_frame(input int smode, input int stop_after);
        int  idx = 0;
        int  n = 0;
        bit  hs;
        while (idx < stop_after && n < 300) begin
            case (smode)
                0:       iS_VALID = 1'b1;
                1:       iS_VALID = (n % 2 == 0);
                default: iS_VALID = 1'($urandom_range(0, 1));
            endcase
            iS_DATA    = iS_VALID ? samples[idx] : 16'($urandom);
            rdy_glitch = (smode == 2 && idx > 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge iCLK);
            hs = iS_VALID && oS_READY;
            @(posedge iCLK); #1;
            if (hs) idx++;
            n++;
        end
        iS_VALID   = 1'b0;
        rdy_glitch = 1'b0;
        check("load_count", idx, stop_after);
    endtask

    task automatic run_frame(input int smode, input int rmode, input int tf,
                             input int hold, input int low, input int dmode);
        int n;
        logic [3:0]  oh;
        logic [21:0] exp_w;
        clear_logs();
        cfg_hold = hold; cfg_low = low; cfg_tf = tf;
        gen_samples(dmode);
        for (int r = 0; r < N; r++)
            exp_res[r] = (tf == 0) ? 16'((r % 4) * 100 + r / 4) : (samples[r] ^ 16'hA5C3);
        iM_READY = (rmode == 0);
        load_frame(smode, N);
        loaded_flag = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            iM_READY = (rmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
            iS_VALID = 1'($urandom_range(0, 1));
            iS_DATA  = 16'($urandom);
            @(posedge iCLK); #1;
            n++;
        end
        iS_VALID = 1'b0;
        iM_READY = 1'b0;
        check("done_seen", done_cnt > 0, 1);
        repeat (3) @(posedge iCLK);
        #1;
        loaded_flag = 1'b0;

        check("wr_count", wr_q.size(), N);
        for (int k = 0; k < N && k < wr_q.size(); k++) begin
            oh    = 4'(1 << (k % 4));
            exp_w = {oh, 2'(k / 4), samples[k]};
            check($sformatf("wr%0d", k), wr_q[k], exp_w);
        end
        check("start_cnt", start_cnt, 1);
        check("start_gap", start_cyc - last_we_cyc, 1);
        check("unload_lat", first_vld_cyc - rise_cyc, 3);
        check("res_count", got_q.size(), N);
        for (int r = 0; r < N && r < got_q.size(); r++)
            check($sformatf("res%0d", r), got_q[r], exp_res[r]);
        check("done_cnt", done_cnt, 1);
        check("done_gap", done_cyc - last_hs_cyc, 1);
        if (rmode == 0) check("throughput", last_hs_cyc - first_vld_cyc, N - 1);
        check("stable_on_stall", stab_viol, 0);
        check("sready_after_load", sready_viol, 0);
        check("busy_end", oBUSY, 0);
    endtask

    initial begin
        iRESET = 1'b0; iS_VALID = 1'b0; iS_DATA = '0; iM_READY = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        check("reset_outputs", {oS_READY, oM_VALID, oM_DATA, oBUSY, oDONE, oFHT_WE,
                                oFHT_START, oFHT_DATA, oFHT_ADDR_WR, oFHT_ADDR_RD}, 0);
        @(negedge iCLK);
        iRESET = 1'b1;
        @(posedge iCLK); #1;

        run_frame(0, 0, 0, 3, 20, 0);
        run_frame(1, 0, 1, 3, 20, 0);
        run_frame(2, 1, 1, $urandom_range(0, 5), $urandom_range(1, 30), 1);

        clear_logs();
        gen_samples(1);
        load_frame(0, 8);
        check("we_before_rst", oFHT_WE, 4'b1000);
        #2 iRESET = 1'b0;
        #1;
        check("rst_async", {oS_READY, oM_VALID, oM_DATA, oBUSY, oDONE, oFHT_WE,
                            oFHT_START, oFHT_DATA, oFHT_ADDR_WR, oFHT_ADDR_RD}, 0);
        repeat (2) @(negedge iCLK);
        check("abort_no_done", done_cnt, 0);
        iRESET = 1'b1;
        @(posedge iCLK); #1;
        run_frame(0, 1, 1, 2, 10, 1);

        for (int f = 0; f < 2; f++)
            run_frame($urandom_range(0, 2), 1, $urandom_range(0, 1),
                      $urandom_range(0, 5), $urandom_range(1, 25), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
